// File: rtl/fake_fpga_pkg.sv
// Shared constants and helpers for the button/LED chain that sits between fake_fpga's buttons and leds.
// The optional sticky-latch feature of the top level is enabled by defining BUTTON_LED_STICKY_EN.
package fake_fpga_pkg;

  localparam logic MODE_XOR    = 1'b0;
  localparam logic MODE_TOGGLE = 1'b1;

  // Width of a counter that must be able to hold the value `cycles`.
  function automatic int unsigned debounce_cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: multi-flop synchroniser, debounce counter, stable level and rising-edge pulse.
module button_debounce
  import fake_fpga_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic stable,
  output logic rise_pulse
);

  localparam int CNT_W = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   synced;

  // Any cycle where the synced level agrees with the stable level discards the count,
  // so only an uninterrupted run of DEBOUNCE_CYCLES disagreements flips the output.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], button};
    synced   = sync_q[SYNC_STAGES-1];
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    if (synced != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = synced;
        rise_d   = synced;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
    end
  end

  assign stable     = stable_q;
  assign rise_pulse = rise_q;

endmodule

// File: rtl/button_led_chain.sv
// N debounced buttons drive N registered LEDs as a prefix-XOR chain (mode 0) or per-channel toggles (mode 1).
// Defining BUTTON_LED_STICKY_EN adds clr/sticky ports that latch each channel's rising edges.
module button_led_chain
  import fake_fpga_pkg::*;
#(
  parameter int N               = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] buttons,
  input  logic         mode,
  output logic [N-1:0] leds,
  output logic [N-1:0] btn_stable,
  output logic [N-1:0] rise_pulse
`ifdef BUTTON_LED_STICKY_EN
  ,
  input  logic [N-1:0] clr,
  output logic [N-1:0] sticky
`endif
);

  logic [N-1:0] chain;
  logic [N-1:0] tog_q, tog_d;
  logic [N-1:0] leds_q, leds_d;

  for (genvar i = 0; i < N; i++) begin : g_chan
    button_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .button    (buttons[i]),
      .stable    (btn_stable[i]),
      .rise_pulse(rise_pulse[i])
    );
  end

  // Toggle state keeps running in XOR mode so switching modes never loses it.
  always_comb begin
    logic acc;
    acc   = 1'b0;
    chain = '0;
    for (int i = 0; i < N; i++) begin
      acc      = acc ^ btn_stable[i];
      chain[i] = acc;
    end
    tog_d  = tog_q ^ rise_pulse;
    leds_d = chain;
    unique case (mode)
      MODE_XOR:    leds_d = chain;
      MODE_TOGGLE: leds_d = tog_q;
      default:     leds_d = chain;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tog_q  <= '0;
      leds_q <= '0;
    end else begin
      tog_q  <= tog_d;
      leds_q <= leds_d;
    end
  end

  assign leds = leds_q;

`ifdef BUTTON_LED_STICKY_EN
  logic [N-1:0] sticky_q, sticky_d;

  // A set arriving in the same cycle as a clear takes priority.
  always_comb begin
    sticky_d = rise_pulse | (sticky_q & ~clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky = sticky_q;
`endif

endmodule

// File: doc/button_led_chain.md
Name: button_led_chain

Overview:
- Parametrised, clocked successor to the fake-FPGA button/LED XOR chain.
- Takes N asynchronous button inputs driven by the fake_fpga VPI model, synchronises and debounces each one, and detects rising edges.
- Drives N registered LEDs in one of two runtime-selectable modes: prefix-XOR chain or per-channel toggle.
- Sits between the fake_fpga instance's buttons output and its leds input.

Parameters:
- N, 8, number of button/LED channels (≥1).
- SYNC_STAGES, 2, synchroniser flops per button (≥2).
- DEBOUNCE_CYCLES, 4, consecutive mismatching cycles needed before the debounced level flips (≥1).

Ports:
- clk  input  1  single system clock; all flops are rising-edge.
- rst  input  1  asynchronous, active-high reset.
- buttons  input  N  raw asynchronous button levels from fake_fpga.
- mode  input  1  0 = XOR-chain mode, 1 = toggle mode; synchronous to clk.
- leds  output  N  registered LED drive, returned to fake_fpga.
- btn_stable  output  N  debounced button levels.
- rise_pulse  output  N  one-cycle pulse per channel on each debounced 0→1 transition.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high (ports clk, rst).
- Reset values: all synchroniser flops, debounce counters, btn_stable, rise_pulse, toggle state and leds clear to 0 immediately on rst assertion, independent of clk.
- Sync: per channel, a chain of SYNC_STAGES flops. The synced bit is the last stage.
- Debounce counter: per channel, width $clog2(DEBOUNCE_CYCLES+1).
  - synced == btn_stable: counter <= 0.
  - synced != btn_stable and counter == DEBOUNCE_CYCLES-1: btn_stable <= synced, counter <= 0.
  - Otherwise counter increments.
- Glitch rejection: a glitch shorter than DEBOUNCE_CYCLES synced cycles resets the counter and never reaches btn_stable.
- Latency: a clean button step reaches btn_stable exactly SYNC_STAGES+DEBOUNCE_CYCLES clock edges after the first edge that samples it. It reaches leds one edge later.
- rise_pulse[i]: registered; high for exactly one cycle, on the same cycle btn_stable[i] first reads 1. No pulse is generated for falls.
- Chain state: chain[0] = btn_stable[0]; chain[i] = chain[i-1] ^ btn_stable[i]. Computed combinationally from btn_stable.
- Toggle state: tog[i] inverts on each rise_pulse[i]. It updates in both modes, so the state is preserved across mode switches.
- Output register: leds <= mode ? tog : chain every cycle. A mode change is visible on leds one edge after mode is sampled.
- Simultaneous events: all channels are independent. Multiple rise pulses in one cycle each toggle their own bit.
- Reset mid-debounce: the count is discarded. After release, a held button requires the full SYNC_STAGES+DEBOUNCE_CYCLES latency again.
- No combinational path from buttons or mode to any output.

Optional Feature:
- Macro: BUTTON_LED_STICKY_EN.
- Defined:
  - Adds input clr (N bits) and output sticky (N bits, reset 0).
  - sticky[i] sets on rise_pulse[i].
  - A clr[i] pulse clears sticky[i]. If set and clear occur in the same cycle, set wins.
- Undefined: neither port exists and no sticky logic is generated.

Decomposition:
- Package fake_fpga_pkg holds:
  - localparam MODE_XOR = 1'b0 and MODE_TOGGLE = 1'b1;
  - a function computing counter width from DEBOUNCE_CYCLES.
- One sub-module, button_debounce: a single channel (synchroniser + counter + stable + rise pulse), parameterised by SYNC_STAGES and DEBOUNCE_CYCLES. It is instantiated N times in a generate loop.
- The top level holds the chain, toggle and output registers.

Test Plan (N=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset check: assert rst mid-cycle with buttons=8'hFF → leds, btn_stable, rise_pulse are 0 immediately, before the next clk edge.
- XOR-chain step: mode=0, buttons 8'h00→8'h01 held → btn_stable=8'h01 at edge 6, leds=8'hFF at edge 7, rise_pulse[0] high for exactly one cycle.
- Glitch rejection: buttons[3] high for 3 synced cycles then low → btn_stable, leds and rise_pulse unchanged throughout.
- Toggle mode: mode=1, press and release buttons[2] twice with clean 10-cycle holds → leds[2] goes 0→1→0, all other bits stay 0. Switch to mode=0 with buttons released → leds=8'h00 one edge later.
- Reset mid-debounce: buttons[5] rises, rst pulses at edge 4, then rst releases with the button still held → btn_stable[5] rises exactly 6 edges after release.
- With BUTTON_LED_STICKY_EN defined: rise on channel 1 with clr[1] pulsed in the same cycle → sticky[1]=1. A later clr[1] alone → sticky[1]=0.
